sad_result_uart_tx: RTL and testbench

//  Serial transmitter for SAD match results; the host-facing end of the UARTsend/UARTsendComplete handshake.

---
 rtl/sad_result_uart_tx_pkg.sv | 42 ++++
 rtl/uart_tx_byte.sv | 58 +++++
 rtl/sad_result_uart_tx.sv | 125 ++++++++++++
 tb/tb_sad_result_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_result_uart_tx_pkg.sv
// Shared definitions for the SAD result transmitter: send-request codes,
// frame header bytes and the frame byte-order helper.
package sad_result_uart_tx_pkg;

  // Request codes driven by control_unit; code 3 is not listed and acts as OFF.
  typedef enum logic [1:0] {
    SEND_OFF       = 2'd0,
    SEND_MATCH     = 2'd1,
    SEND_NOT_MATCH = 2'd2
  } send_code_e;

  localparam logic [7:0] HDR_MATCH_DEFAULT   = 8'h4D;  // 'M'
  localparam logic [7:0] HDR_NOMATCH_DEFAULT = 8'h4E;  // 'N'

  localparam logic [2:0] MATCH_LAST_IDX   = 3'd4;
  localparam logic [2:0] NOMATCH_LAST_IDX = 3'd0;

  // Byte idx of a frame; a no-match frame is just its header byte.
  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic       is_match,
    input logic [9:0] x,
    input logic [8:0] y,
    input logic [7:0] hdr_match,
    input logic [7:0] hdr_nomatch
  );
    logic [7:0] b;
    b = hdr_nomatch;
    if (is_match) begin
      case (idx)
        3'd0:    b = hdr_match;
        3'd1:    b = {6'b0, x[9:8]};
        3'd2:    b = x[7:0];
        3'd3:    b = {7'b0, y[8]};
        3'd4:    b = y[7:0];
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start in the final stop-bit cycle chains the next
// byte with no idle gap; done marks that final cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  logic          r_active;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bit_idx;  // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    r_data;
  logic          r_tx;

  assign tx   = r_tx;
  assign done = r_active && (r_bit_idx == 4'd9) && (r_timer == T_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering between blocks cannot race.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_tx      <= 1'b1;
    end else if (start) begin
      r_active  <= 1'b1;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_data    <= data;
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (r_timer == T_LAST) begin
        r_timer <= '0;
        if (r_bit_idx == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          // Leaving bit k drives bit k+1: data[k] for k<8, stop after data[7].
          r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : r_data[r_bit_idx[2:0]];
        end
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/sad_result_uart_tx.sv
// Host-facing SAD result transmitter: arms on OFF, latches coordinates on a
// MATCH / NOT_MATCH request and shifts the frame out as back-to-back 8N1 bytes.
module sad_result_uart_tx
  import sad_result_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HDR_MATCH    = HDR_MATCH_DEFAULT,
  parameter logic [7:0] HDR_NOMATCH  = HDR_NOMATCH_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] send_req,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  output logic       tx,
  output logic       busy,
  output logic       send_complete
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] r_state;
  logic       r_armed;
  logic       r_is_match;
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic [2:0] r_byte_idx;
  logic       r_busy;
  logic       r_send_complete;

  logic       w_req_match;
  logic       w_req_any;
  logic [2:0] w_last_idx;
  logic       w_ser_start;
  logic [2:0] w_ser_idx;
  logic [7:0] w_ser_data;
  logic       w_ser_done;

  assign w_req_match = (send_req == SEND_MATCH);
  assign w_req_any   = w_req_match || (send_req == SEND_NOT_MATCH);
  assign w_last_idx  = r_is_match ? MATCH_LAST_IDX : NOMATCH_LAST_IDX;

  // The serializer is kicked combinationally so LOAD costs no extra cycle and
  // each following byte starts in the edge right after the previous stop bit.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_ser_start = 1'b0;
    w_ser_idx   = 3'd0;
    case (r_state)
      S_LOAD: w_ser_start = 1'b1;
      S_SEND: begin
        if (w_ser_done && (r_byte_idx != w_last_idx)) begin
          w_ser_start = 1'b1;
          w_ser_idx   = r_byte_idx + 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign w_ser_data = frame_byte(w_ser_idx, r_is_match, r_x, r_y, HDR_MATCH, HDR_NOMATCH);

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clock (clock),
    .reset (reset),
    .start (w_ser_start),
    .data  (w_ser_data),
    .tx    (tx),
    .done  (w_ser_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_armed         <= 1'b1;
      r_is_match      <= 1'b0;
      r_x             <= '0;
      r_y             <= '0;
      r_byte_idx      <= '0;
      r_busy          <= 1'b0;
      r_send_complete <= 1'b0;
    end else begin
      r_send_complete <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_armed && w_req_any) begin
            r_state    <= S_LOAD;
            r_armed    <= 1'b0;
            r_busy     <= 1'b1;
            r_is_match <= w_req_match;
            r_x        <= x_in;
            r_y        <= y_in;
          end else if (!w_req_any) begin
            r_armed <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state    <= S_SEND;
          r_byte_idx <= 3'd0;
        end
        S_SEND: begin
          if (w_ser_done) begin
            if (r_byte_idx == w_last_idx) begin
              r_state         <= S_DONE;
              r_busy          <= 1'b0;
              r_send_complete <= 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;  // S_DONE: one-cycle completion pulse
      endcase
    end
  end

  assign busy          = r_busy;
  assign send_complete = r_send_complete;

endmodule

// File: tb/tb_sad_result_uart_tx.sv
// Self-checking bench for sad_result_uart_tx at CLKS_PER_BIT=4: expected frame
// bytes are queued at request time and popped as the line is decoded mid-bit.
module tb_sad_result_uart_tx;

  localparam int CPB     = 4;
  localparam int BYTE_CY = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] send_req;
  logic [9:0] x_in;
  logic [8:0] y_in;
  logic       tx;
  logic       busy;
  logic       send_complete;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  sad_result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .HDR_MATCH    (8'h4D),
    .HDR_NOMATCH  (8'h4E)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .send_req      (send_req),
    .x_in          (x_in),
    .y_in          (y_in),
    .tx            (tx),
    .busy          (busy),
    .send_complete (send_complete)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_expected(input logic [1:0] code, input logic [9:0] x, input logic [8:0] y);
    if (code == 2'd1) begin
      exp_q.push_back(8'h4D);
      exp_q.push_back({6'b0, x[9:8]});
      exp_q.push_back(x[7:0]);
      exp_q.push_back({7'b0, y[8]});
      exp_q.push_back(y[7:0]);
    end else if (code == 2'd2) begin
      exp_q.push_back(8'h4E);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0 || send_complete !== 1'b0) begin
        fails++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b send_complete=%b, required 1/0/0",
                 name, i, tx, busy, send_complete);
      end
    end
  endtask

  // Request issued before edge 0; checks cycles 0 .. frame+1 (frame+1 = DONE).
  task automatic run_frame(input string name, input logic [1:0] code, input logic [9:0] x,
                           input logic [8:0] y, input bit toggle, input bit release_after);
    int nbytes;
    int flen;
    int rel;
    int b;
    logic [7:0] rx;
    logic [7:0] exp_b;
    nbytes = (code == 2'd1) ? 5 : 1;
    flen   = nbytes * BYTE_CY;
    rx     = 8'h00;
    send_req = code;
    x_in     = x;
    y_in     = y;
    push_expected(code, x, y);
    tick();
    for (int c = 0; c <= flen + 1; c++) begin
      if (c > 0) tick();
      if (toggle && c == 20) begin
        x_in     = ~x;
        y_in     = ~y;
        send_req = 2'd2;
      end
      tests++;
      if (busy !== 1'(c <= flen)) begin
        fails++;
        $display("FAIL %s busy cycle %0d: got %b, required %b", name, c, busy, c <= flen);
      end
      tests++;
      if (send_complete !== 1'(c == flen + 1)) begin
        fails++;
        $display("FAIL %s send_complete cycle %0d: got %b, required %b",
                 name, c, send_complete, c == flen + 1);
      end
      if (c == 0 || c == flen + 1) begin
        tests++;
        if (tx !== 1'b1) begin
          fails++;
          $display("FAIL %s idle tx cycle %0d: got %b, required 1", name, c, tx);
        end
      end else begin
        rel = c - 1;
        if (rel % CPB == CPB / 2) begin
          b = (rel % BYTE_CY) / CPB;
          if (b == 0) begin
            tests++;
            if (tx !== 1'b0) begin
              fails++;
              $display("FAIL %s start bit cycle %0d: got %b, required 0", name, c, tx);
            end
          end else if (b <= 8) begin
            rx[b-1] = tx;
          end else begin
            tests++;
            if (tx !== 1'b1) begin
              fails++;
              $display("FAIL %s stop bit cycle %0d: got %b, required 1", name, c, tx);
            end
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL %s extra byte: got %02h, required none", name, rx);
            end else begin
              exp_b = exp_q.pop_front();
              if (rx !== exp_b) begin
                fails++;
                $display("FAIL %s byte at cycle %0d: got %02h, required %02h", name, c, rx, exp_b);
              end
            end
          end
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s bytes missing: got %0d left over, required 0", name, exp_q.size());
    end
    exp_q.delete();
    if (release_after) begin
      send_req = 2'd0;
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    send_req = 2'd0;
    x_in     = '0;
    y_in     = '0;
    check_idle("reset_hold", 3);
    reset = 1'b0;
    check_idle("reset_idle", 50);
  endtask

  task automatic test_match_frame();
    run_frame("match", 2'd1, 10'h2A5, 9'h1C3, 1'b0, 1'b1);
  endtask

  task automatic test_not_match_frame();
    run_frame("not_match", 2'd2, 10'h3FF, 9'h1FF, 1'b0, 1'b1);
  endtask

  task automatic test_held_request();
    run_frame("held_first", 2'd1, 10'h155, 9'h0AA, 1'b0, 1'b0);
    check_idle("held_no_retrigger", 200);
    send_req = 2'd0;
    tick();
    run_frame("held_rearm", 2'd1, 10'h0F0, 9'h10F, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    send_req = 2'd1;
    x_in     = 10'h2A5;
    y_in     = 9'h1C3;
    tick();
    for (int c = 1; c <= 60; c++) tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset busy before reset: got %b, required 1", busy);
    end
    reset    = 1'b1;
    send_req = 2'd0;
    tick();
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || send_complete !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset after reset: tx=%b busy=%b send_complete=%b, required 1/0/0",
               tx, busy, send_complete);
    end
    check_idle("mid_reset_hold", 2);
    reset = 1'b0;
    check_idle("mid_reset_quiet", 5);
    run_frame("after_reset", 2'd1, 10'h2A5, 9'h1C3, 1'b0, 1'b1);
  endtask

  task automatic test_input_stability();
    run_frame("stability_match", 2'd1, 10'h13C, 9'h0E7, 1'b1, 1'b1);
  endtask

  task automatic test_code3_ignored();
    send_req = 2'd3;
    check_idle("code3", 30);
    send_req = 2'd0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] code;
    for (int i = 0; i < 4; i++) begin
      x    = 10'($urandom_range(0, 1023));
      y    = 9'($urandom_range(0, 511));
      code = (i % 2 == 0) ? 2'd1 : 2'd2;
      run_frame("back_to_back", code, x, y, 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_match_frame();
    test_not_match_frame();
    test_held_request();
    test_reset_mid_frame();
    test_input_stability();
    test_code3_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
